fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipeline. Owns the program counter, drives the word address into the instruction memory, captures the returned instruction into the IF/ID pipeline register, resolves unconditional jumps locally, and obeys stall and redirect commands from the hazard unit and EX stage. Sits directly upstream of the instruction memory and feeds the decode stage.

## Interface
- `PC_W`, 32: program counter and address width.
- `RESET_PC`, 0: word address fetched first after reset.
- `IMEM_DEPTH`, 101: number of valid instruction words. Addresses ≥ IMEM_DEPTH are out of range.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard unit request to hold the PC and the IF/ID register.
- `redirect_valid` in 1: EX stage has resolved a taken branch.
- `redirect_pc` in PC_W: target word address for the branch.
- `imem_addr` out PC_W: word address to the instruction memory. This output equals the PC.
- `imem_instr` in 32: instruction word. It is combinational from `imem_addr` in the same cycle.
- `ifid_valid` out 1: the IF/ID register holds a real instruction. When 0, it holds a bubble.
- `ifid_instr` out 32: latched instruction. Value is 32'h0 when `ifid_valid`=0.
- `ifid_pc` out PC_W: address of the latched instruction.
- `ifid_pc_plus1` out PC_W: `ifid_pc`+1.
- `halted` out 1: the fetch unit is in the HALT state.

## Operation
- States:
  - BOOT: the first cycle after reset release. `imem_addr`=RESET_PC. The IF/ID register captures nothing.
  - RUN: normal fetching.
  - HALT: the PC has gone out of range.
- Transitions:
  - BOOT→RUN unconditionally.
  - RUN→HALT when the next PC is ≥ IMEM_DEPTH and no redirect is pending.
  - HALT→RUN on `redirect_valid` with `redirect_pc` < IMEM_DEPTH.
  - Reset from any state → BOOT.
- Next-PC priority, highest first:
  1. `redirect_valid`: PC ← `redirect_pc`. The IF/ID register is flushed to a bubble, even if `stall` is asserted.
  2. `stall`: PC and IF/ID register hold.
  3. Predecoded jump: `imem_instr[31:26]`=OP_JUMP gives PC ← zero-extend(`imem_instr[25:0]`). The jump itself is latched valid. No bubble is inserted.
  4. Default: PC ← PC+1. The fetched word is latched valid.
- Arithmetic: PC+1 wraps modulo 2^PC_W. A wrap to 0 is in range and does not halt.
- Jump target: zero-extended from 26 bits. If PC_W < 26, it is truncated to PC_W.
- HALT behaviour:
  - PC is frozen at the out-of-range value.
  - `ifid_valid`=0 and `ifid_instr`=0 every cycle.
  - `stall` is ignored.
- Branches (OP_BRANCH) are not resolved here. They are fetched like any other word.

## Timing
- Reset values:
  - PC = RESET_PC.
  - State = BOOT.
  - `ifid_valid`=0, `ifid_instr`=0, `ifid_pc`=0, `ifid_pc_plus1`=0.
  - `halted`=0.
- Fetch-to-decode latency: 1 cycle. The word at `imem_addr` in cycle N appears on `ifid_*` after edge N+1.
- Taken branch penalty:
  - `redirect_valid` in cycle N gives `imem_addr`=`redirect_pc` and `ifid_valid`=0 in cycle N+1.
  - The target instruction reaches IF/ID in cycle N+2.
- Jump penalty: 0 cycles. The target is fetched in the cycle after the jump is fetched.
- `stall` is level-sensitive. There is no limit on how long it may be held. Outputs are stable while it is held.
- Reset asserted mid-operation:
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - A pending redirect is discarded.
- `halted` is registered. It asserts on the edge that enters HALT.

## Structure
- Shared package `pipeline_pkg` holds:
  - OP_JUMP = 6'b100000 and OP_BRANCH = 6'b010110.
  - NOP_INSTR = 32'h0.
  - The fetch state encoding (BOOT, RUN, HALT).
  - The IF/ID field layout.
- Sub-module `ifid_reg` is the IF/ID pipeline register. It has load, hold and flush controls and carries valid, instruction, PC and PC+1.
- `fetch_stage` contains the PC register, the next-PC mux, the jump predecoder and the FSM.

## Test plan
- Reset, then free-running fetch:
  - `imem_addr` runs 0,1,2,3.
  - `ifid_pc` runs 0,1,2 from the second RUN edge.
  - `ifid_pc_plus1`=`ifid_pc`+1.
- Jump at word 7 with `imem_instr`=32'h8000_0009:
  - The next `imem_addr` is 9.
  - `ifid` shows pc 7 then 9, with `ifid_valid` high on both.
- `redirect_valid`=1 with `redirect_pc`=5 while PC=4:
  - Next cycle: `imem_addr`=5, `ifid_valid`=0, `ifid_instr`=0.
  - Following cycle: `ifid_pc`=5.
- `stall` held 3 cycles at PC=2: `imem_addr` and all `ifid_*` outputs are unchanged. Fetch resumes at 3.
- `stall` and `redirect_valid` asserted together (target 8): the redirect wins and IF/ID is flushed. Then fetch continues from PC=101:
  - `halted`=1 and the PC freezes.
  - A later redirect to 0 clears `halted` and fetch restarts at 0.
- `rst_n` pulled low mid-cycle while PC=6: outputs reset asynchronously. After release, the first fetch is RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Opcodes, fetch FSM encoding and IF/ID layout shared by the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam logic [5:0]  OP_JUMP   = 6'b100000;
    localparam logic [5:0]  OP_BRANCH = 6'b010110;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

    // PC-independent part of the IF/ID register; PC fields are sized per instance.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
    } ifid_hdr_t;

    function automatic logic is_jump(input logic [31:0] instr);
        return instr[31:26] == OP_JUMP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifid_reg.sv
// ============================================================================
// Module   : ifid_reg
// Purpose  : IF/ID pipeline register with flush > hold > load priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifid_reg
    import pipeline_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_hold,
    input  logic            i_flush,
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_pc_plus1,
    output logic            o_valid,
    output logic [31:0]     o_instr,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_plus1
);

    ifid_hdr_t       r_hdr;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_pc_plus1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr      <= '{valid: 1'b0, instr: NOP_INSTR};
            r_pc       <= '0;
            r_pc_plus1 <= '0;
        end else if (i_flush) begin
            r_hdr      <= '{valid: 1'b0, instr: NOP_INSTR};
            r_pc       <= '0;
            r_pc_plus1 <= '0;
        end else if (!i_hold && i_load) begin
            r_hdr      <= '{valid: 1'b1, instr: i_instr};
            r_pc       <= i_pc;
            r_pc_plus1 <= i_pc_plus1;
        end
    end

    assign o_valid    = r_hdr.valid;
    assign o_instr    = r_hdr.instr;
    assign o_pc       = r_pc;
    assign o_pc_plus1 = r_pc_plus1;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC, next-PC selection, jump predecode and fetch FSM feeding IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              IMEM_DEPTH = 101
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    output logic            ifid_valid,
    output logic [31:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc,
    output logic [PC_W-1:0] ifid_pc_plus1,
    output logic            halted
);

    localparam logic [PC_W-1:0] c_imem_depth = PC_W'(IMEM_DEPTH);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_halted;

    logic [PC_W-1:0] w_pc_plus1;
    logic [PC_W-1:0] w_jump_tgt;
    logic [PC_W-1:0] w_next_pc;
    logic            w_next_oob;
    logic            w_redirect_ok;

    assign w_pc_plus1    = r_pc + PC_W'(1);
    // The size cast zero-extends or truncates the 26-bit target to PC_W.
    assign w_jump_tgt    = PC_W'(imem_instr[25:0]);
    assign w_redirect_ok = redirect_pc < c_imem_depth;

    always_comb begin
        w_next_pc = w_pc_plus1;
        if (redirect_valid)
            w_next_pc = redirect_pc;
        else if (stall)
            w_next_pc = r_pc;
        else if (is_jump(imem_instr))
            w_next_pc = w_jump_tgt;
    end

    assign w_next_oob = w_next_pc >= c_imem_depth;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FS_BOOT;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                FS_BOOT: r_state <= FS_RUN;
                FS_RUN: begin
                    r_pc <= w_next_pc;
                    if (!redirect_valid && w_next_oob) begin
                        r_state  <= FS_HALT;
                        r_halted <= 1'b1;
                    end
                end
                FS_HALT: begin
                    if (redirect_valid && w_redirect_ok) begin
                        r_pc     <= redirect_pc;
                        r_state  <= FS_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= FS_BOOT;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // HALT flushes every cycle regardless of stall; BOOT leaves the bubble in place.
    ifid_reg #(
        .PC_W (PC_W)
    ) u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (r_state == FS_RUN),
        .i_hold     ((r_state == FS_BOOT) || stall),
        .i_flush    ((r_state == FS_HALT) || ((r_state == FS_RUN) && redirect_valid)),
        .i_instr    (imem_instr),
        .i_pc       (r_pc),
        .i_pc_plus1 (w_pc_plus1),
        .o_valid    (ifid_valid),
        .o_instr    (ifid_instr),
        .o_pc       (ifid_pc),
        .o_pc_plus1 (ifid_pc_plus1)
    );

    assign imem_addr = r_pc;
    assign halted    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed plus randomized checks of fetch_stage against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam int DEPTH = 101;
    localparam int S_BOOT = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus1;
    logic        halted;

    logic [31:0] mem [0:DEPTH-1];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_st;
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    fetch_stage #(
        .PC_W       (32),
        .RESET_PC   (32'h0),
        .IMEM_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus1  (ifid_pc_plus1),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    always_comb imem_instr = (imem_addr < 32'(DEPTH)) ? mem[imem_addr[6:0]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] plain_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'b100000) w[31] = 1'b0;
        return w;
    endfunction

    task automatic model_reset();
        m_st = S_BOOT; m_pc = 32'h0; m_v = 1'b0; m_instr = 32'h0; m_ipc = 32'h0;
    endtask

    task automatic model_bubble();
        m_v = 1'b0; m_instr = 32'h0; m_ipc = 32'h0;
    endtask

    // One rising edge of the fetch stage, computed from the behavioural rules.
    task automatic model_edge(input logic st, input logic rv, input logic [31:0] rpc);
        logic [31:0] w;
        if (m_st == S_BOOT) begin
            m_st = S_RUN;
        end else if (m_st == S_HALT) begin
            model_bubble();
            if (rv && rpc < 32'(DEPTH)) begin
                m_pc = rpc;
                m_st = S_RUN;
            end
        end else if (rv) begin
            m_pc = rpc;
            model_bubble();
        end else if (!st) begin
            w = (m_pc < 32'(DEPTH)) ? mem[m_pc[6:0]] : 32'h0;
            m_v = 1'b1; m_instr = w; m_ipc = m_pc;
            m_pc = (w[31:26] == 6'b100000) ? {6'b0, w[25:0]} : m_pc + 32'd1;
            if (m_pc >= 32'(DEPTH)) m_st = S_HALT;
        end
    endtask

    task automatic compare_all();
        check("imem_addr", imem_addr, m_pc);
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_v});
        check("ifid_instr", ifid_instr, m_instr);
        check("halted", {31'b0, halted}, {31'b0, m_st == S_HALT});
        if (m_v) begin
            check("ifid_pc", ifid_pc, m_ipc);
            check("ifid_pc_plus1", ifid_pc_plus1, m_ipc + 32'd1);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(stall, redirect_valid, redirect_pc);
        #1;
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {6'b000001, 26'(i)};
        mem[7] = 32'h8000_0009;

        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
        check("rst_ifid_pc", ifid_pc, 32'd0);
        check("rst_ifid_pc_plus1", ifid_pc_plus1, 32'd0);
        compare_all();
        #14 rst_n = 1'b1;

        cycle();                                   // BOOT -> RUN
        check("boot_addr", imem_addr, 32'd0);
        cycle();
        cycle();
        check("run_addr2", imem_addr, 32'd2);
        check("run_ifid_pc1", ifid_pc, 32'd1);

        stall = 1'b1;
        repeat (3) cycle();
        check("stall_addr", imem_addr, 32'd2);
        check("stall_ifid_pc", ifid_pc, 32'd1);
        stall = 1'b0;
        cycle();
        check("resume_addr", imem_addr, 32'd3);
        cycle();                                   // PC = 4

        redirect_valid = 1'b1; redirect_pc = 32'd5;
        cycle();
        check("redir_addr", imem_addr, 32'd5);
        check("redir_bubble", {31'b0, ifid_valid}, 32'd0);
        redirect_valid = 1'b0;
        cycle();
        check("redir_tgt_pc", ifid_pc, 32'd5);
        cycle();                                   // PC = 7, jump word
        cycle();
        check("jump_addr", imem_addr, 32'd9);
        check("jump_ifid_pc", ifid_pc, 32'd7);
        cycle();
        check("jump_tgt_pc", ifid_pc, 32'd9);
        check("jump_tgt_valid", {31'b0, ifid_valid}, 32'd1);

        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd8;
        cycle();
        check("stall_redir_addr", imem_addr, 32'd8);
        stall = 1'b0; redirect_valid = 1'b0;

        for (int i = 0; i < 200 && !halted; i++) cycle();
        check("halt_reached", {31'b0, halted}, 32'd1);
        check("halt_addr", imem_addr, 32'd101);
        for (int i = 0; i < 4; i++) begin
            stall = i[0];
            cycle();
        end
        stall = 1'b0;
        check("halt_frozen", imem_addr, 32'd101);
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        cycle();
        check("unhalt", {31'b0, halted}, 32'd0);
        check("unhalt_addr", imem_addr, 32'd0);
        redirect_valid = 1'b0;
        repeat (6) cycle();
        check("pre_reset_addr", imem_addr, 32'd6);

        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk) rst_n = 1'b1;
        cycle();
        check("post_reset_addr", imem_addr, 32'd0);

        // Randomized phase: random program with jumps, random stall/redirect traffic.
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 7) == 0)
                mem[i] = {6'b100000, 26'($urandom_range(0, 115))};
            else
                mem[i] = plain_word();
        end
        for (int n = 0; n < 600; n++) begin
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0) || (m_st == S_HALT && $urandom_range(0, 2) == 0);
            if (m_st == S_HALT && $urandom_range(0, 3) == 0)
                redirect_pc = 32'($urandom_range(101, 130));
            else
                redirect_pc = 32'($urandom_range(0, 100));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
